// File: rtl/ham_scrub_ctrl.sv
// Hamming(7,4) memory scrubber: walks every codeword, writes back single-bit corrections.
// Define HAM_SCRUB_LOG_EN to add last_err_addr/last_err_pos/last_err_data capture ports.
module ham_scrub_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [6:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [6:0]        mem_wdata,
    output logic [6:0]        dec_code,
    input  logic [3:0]        dec_data,
    input  logic [2:0]        dec_pos,
    input  logic              dec_err,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count
`ifdef HAM_SCRUB_LOG_EN
    ,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic [2:0]        last_err_pos,
    output logic [3:0]        last_err_data
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        CHECK,
        WRITE,
        NEXT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        code_q;
    logic [6:0]        flip_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    state_next = CAPT;
            CAPT:    state_next = CHECK;
            CHECK:   state_next = (dec_err && (dec_pos != 3'd0)) ? WRITE : NEXT;
            WRITE:   state_next = NEXT;
            NEXT:    state_next = (addr == LAST_ADDR) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // abort overrides everything once a pass is running
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            code_q    <= 7'd0;
            err_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= '0;
                        err_count <= 8'd0;
                    end
                end
                CAPT:  code_q <= mem_rdata;
                WRITE: begin
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                NEXT: begin
                    if (addr != LAST_ADDR) begin
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        flip_mask = 7'd0;
        if (dec_pos != 3'd0) begin
            flip_mask = 7'd1 << (dec_pos - 3'd1);
        end
    end

    assign mem_addr  = addr;
    assign mem_rd_en = (state == READ);
    assign mem_wr_en = (state == WRITE);
    assign mem_wdata = (state == WRITE) ? (code_q ^ flip_mask) : 7'd0;
    assign dec_code  = code_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef HAM_SCRUB_LOG_EN
    // Log survives start so software can inspect the most recent correction later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_err_addr <= '0;
            last_err_pos  <= 3'd0;
            last_err_data <= 4'd0;
        end else if (state == WRITE) begin
            last_err_addr <= addr;
            last_err_pos  <= dec_pos;
            last_err_data <= dec_data;
        end
    end
`else
    logic unused_dec_data;
    assign unused_dec_data = ^dec_data;
`endif

endmodule

// File: tb/tb_ham_scrub_ctrl.sv
// Directed self-checking bench for ham_scrub_ctrl with a 16-word memory and table-driven decoder stub.
// Log-port checks are compiled in when HAM_SCRUB_LOG_EN is defined.
module tb_ham_scrub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] mem_addr;
    logic       mem_rd_en;
    logic [6:0] mem_rdata;
    logic       mem_wr_en;
    logic [6:0] mem_wdata;
    logic [6:0] dec_code;
    logic [3:0] dec_data;
    logic [2:0] dec_pos;
    logic       dec_err;
    logic       busy;
    logic       done;
    logic [7:0] err_count;
`ifdef HAM_SCRUB_LOG_EN
    logic [3:0] last_err_addr;
    logic [2:0] last_err_pos;
    logic [3:0] last_err_data;
`endif

    logic [6:0] mem      [16];
    logic [6:0] init_mem [16];
    logic [2:0] pos_tbl  [16];
    logic       err_tbl  [16];
    logic [3:0] data_tbl [16];
    logic       load_req;
    logic [3:0] rd_addr;
    logic [3:0] last_wr_addr;
    logic [6:0] last_wr_data;
    int rd_count = 0;
    int wr_count = 0;
    int done_count = 0;
    int overlap_count = 0;
    int wdata_bad_count = 0;

    int checks = 0;
    int failures = 0;

    ham_scrub_ctrl #(.ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .dec_code  (dec_code),
        .dec_data  (dec_data),
        .dec_pos   (dec_pos),
        .dec_err   (dec_err),
        .busy      (busy),
        .done      (done),
        .err_count (err_count)
`ifdef HAM_SCRUB_LOG_EN
        ,
        .last_err_addr (last_err_addr),
        .last_err_pos  (last_err_pos),
        .last_err_data (last_err_data)
`endif
    );

    always #5 clk = ~clk;

    // Decoder stub answers for the word most recently read
    assign dec_pos  = pos_tbl[rd_addr];
    assign dec_err  = err_tbl[rd_addr];
    assign dec_data = data_tbl[rd_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        end else begin
            if (mem_rd_en) begin
                mem_rdata <= mem[mem_addr];
                rd_addr   <= mem_addr;
                rd_count  <= rd_count + 1;
            end
            if (mem_wr_en) begin
                mem[mem_addr] <= mem_wdata;
                last_wr_addr  <= mem_addr;
                last_wr_data  <= mem_wdata;
                wr_count      <= wr_count + 1;
            end
            if (done) done_count <= done_count + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en && mem_wr_en) overlap_count <= overlap_count + 1;
        if (!mem_wr_en && (mem_wdata != 7'd0)) wdata_bad_count <= wdata_bad_count + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic load_clean();
        for (int i = 0; i < 16; i++) begin
            init_mem[i] = 7'd0;
            pos_tbl[i]  = 3'd0;
            err_tbl[i]  = 1'b0;
            data_tbl[i] = 4'(i);
        end
    endtask

    task automatic commit_mem();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // Returns cycles from the start cycle (counted as 1) through the done cycle, or -1 on timeout
    task automatic run_pass(input int mid_start, input logic with_abort, output int cycles);
        start = 1'b1;
        abort = with_abort;
        cycles = 1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        cycles = 2;
        checks++;
        if (!(mem_rd_en === 1'b1 && mem_addr === 4'd0)) begin
            failures++;
            $display("[TB] FAIL first_read: rd_en=%b addr=%0d, expected rd_en=1 addr=0", mem_rd_en, mem_addr);
        end
        while (done !== 1'b1 && cycles < 300) begin
            start = (cycles == mid_start);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        if (done !== 1'b1) cycles = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        load_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000", {busy, done, mem_rd_en, mem_wr_en});
        end
        checks++;
        if ({mem_addr, err_count, dec_code, mem_wdata} !== 26'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: addr=%0d err=%0d code=%h wdata=%h expected all 0",
                     mem_addr, err_count, dec_code, mem_wdata);
        end
`ifdef HAM_SCRUB_LOG_EN
        checks++;
        if ({last_err_addr, last_err_pos, last_err_data} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL reset_log: got %h/%h/%h expected 0/0/0", last_err_addr, last_err_pos, last_err_data);
        end
`endif
        load_clean();
        commit_mem();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_hold: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_clean_pass();
        int cyc, w0, r0, d0;
        load_clean();
        commit_mem();
        w0 = wr_count; r0 = rd_count; d0 = done_count;
        run_pass(0, 1'b0, cyc);
        checks++;
        if (cyc !== 66) begin failures++; $display("[TB] FAIL clean_cycles: got %0d expected 66", cyc); end
        checks++;
        if (wr_count - w0 !== 0) begin failures++; $display("[TB] FAIL clean_writes: got %0d expected 0", wr_count - w0); end
        checks++;
        if (rd_count - r0 !== 16) begin failures++; $display("[TB] FAIL clean_reads: got %0d expected 16", rd_count - r0); end
        checks++;
        if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL clean_done: got %0d expected 1", done_count - d0); end
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("[TB] FAIL clean_errcnt: got %0d expected 0", err_count); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL clean_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_error();
        int cyc, w0;
        load_clean();
        init_mem[3] = 7'b1010101;
        pos_tbl[3]  = 3'd7;
        err_tbl[3]  = 1'b1;
        commit_mem();
        w0 = wr_count;
        run_pass(0, 1'b0, cyc);
        checks++;
        if (cyc !== 67) begin failures++; $display("[TB] FAIL single_cycles: got %0d expected 67", cyc); end
        checks++;
        if (wr_count - w0 !== 1) begin failures++; $display("[TB] FAIL single_writes: got %0d expected 1", wr_count - w0); end
        checks++;
        if (last_wr_addr !== 4'd3) begin failures++; $display("[TB] FAIL single_waddr: got %0d expected 3", last_wr_addr); end
        checks++;
        if (last_wr_data !== 7'b0010101) begin failures++; $display("[TB] FAIL single_wdata: got %b expected 0010101", last_wr_data); end
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL single_errcnt: got %0d expected 1", err_count); end
        checks++;
        if (mem[3] !== 7'b0010101) begin failures++; $display("[TB] FAIL single_mem: got %b expected 0010101", mem[3]); end
    endtask

    task automatic test_all_errors();
        int cyc, w0, p;
        logic [6:0] good [16];
        load_clean();
        for (int i = 0; i < 16; i++) begin
            p = (i % 7) + 1;
            good[i]     = 7'(i * 9 + 5);
            init_mem[i] = good[i] ^ (7'd1 << (p - 1));
            pos_tbl[i]  = 3'(p);
            err_tbl[i]  = 1'b1;
        end
        commit_mem();
        w0 = wr_count;
        run_pass(0, 1'b0, cyc);
        checks++;
        if (cyc !== 82) begin failures++; $display("[TB] FAIL all_cycles: got %0d expected 82", cyc); end
        checks++;
        if (wr_count - w0 !== 16) begin failures++; $display("[TB] FAIL all_writes: got %0d expected 16", wr_count - w0); end
        checks++;
        if (err_count !== 8'd16) begin failures++; $display("[TB] FAIL all_errcnt: got %0d expected 16", err_count); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== good[i]) begin
                failures++;
                $display("[TB] FAIL all_mem[%0d]: got %b expected %b", i, mem[i], good[i]);
            end
        end
    endtask

    task automatic test_abort();
        int n, r0, w0, d0;
        load_clean();
        init_mem[2] = 7'b0000100;
        pos_tbl[2]  = 3'd3;
        err_tbl[2]  = 1'b1;
        init_mem[5] = 7'b0110011;
        commit_mem();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr === 4'd5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin failures++; $display("[TB] FAIL abort_reach: read of word 5 not seen, got timeout expected read"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (dec_code !== 7'b0110011) begin failures++; $display("[TB] FAIL abort_deccode: got %b expected 0110011", dec_code); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL abort_idle: busy/done/rd/wr got %b expected 0000", {busy, done, mem_rd_en, mem_wr_en});
        end
        r0 = rd_count; w0 = wr_count; d0 = done_count;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({rd_count - r0, wr_count - w0, done_count - d0} !== 96'd0) begin
            failures++;
            $display("[TB] FAIL abort_quiet: rd=%0d wr=%0d done=%0d expected 0/0/0", rd_count - r0, wr_count - w0, done_count - d0);
        end
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL abort_errcnt: got %0d expected 1", err_count); end
    endtask

    task automatic test_reset_mid_write();
        int n, w0, cyc;
        load_clean();
        init_mem[2] = 7'b1000000;
        pos_tbl[2]  = 3'd7;
        err_tbl[2]  = 1'b1;
        commit_mem();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (mem_wr_en !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem_addr !== 4'd2) begin failures++; $display("[TB] FAIL rstw_addr: got %0d expected 2", mem_addr); end
        w0 = wr_count;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rstw_strobes: got %b expected 0000", {busy, done, mem_rd_en, mem_wr_en});
        end
        checks++;
        if ({mem_addr, err_count, dec_code} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL rstw_values: addr=%0d err=%0d code=%b expected 0/0/0", mem_addr, err_count, dec_code);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_count !== w0 || mem[2] !== 7'b1000000) begin
            failures++;
            $display("[TB] FAIL rstw_nowrite: writes=%0d mem2=%b expected %0d/1000000", wr_count, mem[2], w0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_pass(0, 1'b0, cyc);
        checks++;
        if (cyc !== 67) begin failures++; $display("[TB] FAIL rstw_cycles: got %0d expected 67", cyc); end
        checks++;
        if (err_count !== 8'd1 || mem[2] !== 7'd0) begin
            failures++;
            $display("[TB] FAIL rstw_rescrub: err=%0d mem2=%b expected 1/0000000", err_count, mem[2]);
        end
    endtask

    task automatic test_start_abort_idle();
        int cyc, d0;
        load_clean();
        commit_mem();
        d0 = done_count;
        run_pass(20, 1'b1, cyc);
        checks++;
        if (cyc !== 66) begin failures++; $display("[TB] FAIL busy_start_cycles: got %0d expected 66", cyc); end
        checks++;
        if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL busy_start_done: got %0d expected 1", done_count - d0); end
    endtask

    task automatic test_uncorrectable_log();
        int cyc, w0;
        load_clean();
        init_mem[4]  = 7'b0000010; pos_tbl[4]  = 3'd2; err_tbl[4]  = 1'b1; data_tbl[4] = 4'hA;
        init_mem[9]  = 7'b0100000; pos_tbl[9]  = 3'd6; err_tbl[9]  = 1'b1; data_tbl[9] = 4'h5;
        init_mem[11] = 7'b0000011; pos_tbl[11] = 3'd0; err_tbl[11] = 1'b1;
        commit_mem();
        w0 = wr_count;
        run_pass(0, 1'b0, cyc);
        checks++;
        if (cyc !== 68) begin failures++; $display("[TB] FAIL unc_cycles: got %0d expected 68", cyc); end
        checks++;
        if (wr_count - w0 !== 2) begin failures++; $display("[TB] FAIL unc_writes: got %0d expected 2", wr_count - w0); end
        checks++;
        if (err_count !== 8'd2) begin failures++; $display("[TB] FAIL unc_errcnt: got %0d expected 2", err_count); end
        checks++;
        if ({mem[4], mem[9], mem[11]} !== {7'd0, 7'd0, 7'b0000011}) begin
            failures++;
            $display("[TB] FAIL unc_mem: got %b/%b/%b expected 0000000/0000000/0000011", mem[4], mem[9], mem[11]);
        end
`ifdef HAM_SCRUB_LOG_EN
        checks++;
        if ({last_err_addr, last_err_pos, last_err_data} !== {4'd9, 3'd6, 4'h5}) begin
            failures++;
            $display("[TB] FAIL log_last: got %0d/%0d/%h expected 9/6/5", last_err_addr, last_err_pos, last_err_data);
        end
`endif
        load_clean();
        commit_mem();
        run_pass(0, 1'b0, cyc);
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("[TB] FAIL restart_errcnt: got %0d expected 0", err_count); end
`ifdef HAM_SCRUB_LOG_EN
        checks++;
        if ({last_err_addr, last_err_pos, last_err_data} !== {4'd9, 3'd6, 4'h5}) begin
            failures++;
            $display("[TB] FAIL log_retain: got %0d/%0d/%h expected 9/6/5", last_err_addr, last_err_pos, last_err_data);
        end
`endif
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap_count !== 0) begin failures++; $display("[TB] FAIL rd_wr_overlap: got %0d cycles expected 0", overlap_count); end
        checks++;
        if (wdata_bad_count !== 0) begin failures++; $display("[TB] FAIL idle_wdata: got %0d nonzero cycles expected 0", wdata_bad_count); end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_single_error();
        test_all_errors();
        test_abort();
        test_reset_mid_write();
        test_start_abort_idle();
        test_uncorrectable_log();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
